// File: rtl/hdc_hf_pkg.sv
// Shared definitions for the hdc_hf encoder blocks (binder, bundler, similarity).
package hdc_hf_pkg;

  localparam int DEF_DIMENSIONS = 5;

  // Counter width able to hold the values 0..n
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } hf_state_e;

endpackage

// File: rtl/bundle_counter_hf.sv
// Ones-counter for a single hypervector dimension.
// On load it restarts from the incoming bit. On inc it adds the incoming bit.
module bundle_counter_hf
  import hdc_hf_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic             inc,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count
);

  // Clear on reset, restart on load, count ones on inc
  always_ff @(posedge clk) begin
    if (nrst)
      count <= '0;
    else if (load)
      count <= CNT_W'(bit_in);
    else if (inc && bit_in)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/bundler_hf.sv
// Bitwise-majority bundler: accumulates NUM_INPUTS hypervectors and
// emits their per-dimension majority with a one-cycle out pulse.
module bundler_hf
  import hdc_hf_pkg::*;
#(
  parameter int DIMENSIONS = DEF_DIMENSIONS,
  parameter int NUM_INPUTS = 3,
  parameter bit TIE_ONE    = 1'b0
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [DIMENSIONS-1:0] hv_in,
  output logic                  out,
  output logic [DIMENSIONS-1:0] hv_out
);

  localparam int CNT_W = cnt_width(NUM_INPUTS);

  hf_state_e                              state;
  logic [CNT_W-1:0]                       acc_cnt;
  logic [DIMENSIONS-1:0][CNT_W-1:0]       cnt;
  logic [DIMENSIONS-1:0][CNT_W-1:0]       cnt_nxt;
  logic [DIMENSIONS-1:0]                  maj_nxt;
  logic                                   load;
  logic                                   inc;
  logic                                   fin;

  // IDLE and DONE start a fresh bundle; ACCUM adds to the running one
  assign load = en && (state != ACCUM);
  assign inc  = en && (state == ACCUM);

  // The accepted vector completes the bundle
  assign fin = load ? (NUM_INPUTS == 1)
                    : (inc && (acc_cnt == CNT_W'(NUM_INPUTS - 1)));

  genvar g;
  generate
    for (g = 0; g < DIMENSIONS; g++) begin : g_cnt
      bundle_counter_hf #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .nrst   (nrst),
        .load   (load),
        .inc    (inc),
        .bit_in (hv_in[g]),
        .count  (cnt[g])
      );
    end
  endgenerate

  // Post-accept counts and their majority, so hv_out can be registered on the
  // same edge that enters DONE and is valid alongside out
  always_comb begin
    cnt_nxt = '0;
    maj_nxt = '0;
    for (int i = 0; i < DIMENSIONS; i++) begin
      logic [CNT_W:0] dbl;
      cnt_nxt[i] = load ? CNT_W'(hv_in[i]) : (cnt[i] + CNT_W'(hv_in[i]));
      dbl        = {cnt_nxt[i], 1'b0};
      if (dbl > (CNT_W + 1)'(NUM_INPUTS))
        maj_nxt[i] = 1'b1;
      else if (dbl == (CNT_W + 1)'(NUM_INPUTS))
        maj_nxt[i] = TIE_ONE;
      else
        maj_nxt[i] = 1'b0;
    end
  end

  // Control FSM with registered out / hv_out
  always_ff @(posedge clk) begin
    if (nrst) begin
      state   <= IDLE;
      acc_cnt <= '0;
      out     <= 1'b0;
      hv_out  <= '0;
    end else begin
      out <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (en) begin
            acc_cnt <= CNT_W'(1);
            state   <= fin ? DONE : ACCUM;
          end else begin
            acc_cnt <= '0;
            state   <= IDLE;
          end
        end
        ACCUM: begin
          if (en) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (fin) state <= DONE;
          end
        end
        default: begin
          acc_cnt <= '0;
          state   <= IDLE;
        end
      endcase
      if (fin) begin
        out    <= 1'b1;
        hv_out <= maj_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bundler_hf.sv
// Directed bench for bundler_hf: N=3 main instance, N=2 tie instances, N=1 passthrough.
module tb_bundler_hf;

  localparam int D = 5;

  logic         clk = 1'b0;
  logic         nrst;
  logic         en3, en2, en1;
  logic [D-1:0] hv_in;
  logic         out3, out2a, out2b, out1;
  logic [D-1:0] hv3, hv2a, hv2b, hv1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bundler_hf #(.DIMENSIONS(D), .NUM_INPUTS(3), .TIE_ONE(1'b0)) dut3 (
    .clk(clk), .nrst(nrst), .en(en3), .hv_in(hv_in), .out(out3), .hv_out(hv3));
  bundler_hf #(.DIMENSIONS(D), .NUM_INPUTS(2), .TIE_ONE(1'b0)) dut2a (
    .clk(clk), .nrst(nrst), .en(en2), .hv_in(hv_in), .out(out2a), .hv_out(hv2a));
  bundler_hf #(.DIMENSIONS(D), .NUM_INPUTS(2), .TIE_ONE(1'b1)) dut2b (
    .clk(clk), .nrst(nrst), .en(en2), .hv_in(hv_in), .out(out2b), .hv_out(hv2b));
  bundler_hf #(.DIMENSIONS(D), .NUM_INPUTS(1), .TIE_ONE(1'b0)) dut1 (
    .clk(clk), .nrst(nrst), .en(en1), .hv_in(hv_in), .out(out1), .hv_out(hv1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", tag, obs[D-1:0], exp[D-1:0]);
    end
  endtask

  // advance one edge; outputs sampled 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one vector to the N=3 instance for a single cycle
  task automatic put3(input logic [D-1:0] v);
    en3 = 1'b1; hv_in = v;
    step();
    en3 = 1'b0;
  endtask

  initial begin
    nrst = 1'b1; en3 = 1'b0; en2 = 1'b0; en1 = 1'b0; hv_in = '0;
    #2;
    repeat (10) step();
    chk("rst_out", out3, 0);
    chk("rst_hv", hv3, 0);
    chk("rst_out1", out1, 0);
    nrst = 1'b0;

    // 1: basic majority with gaps
    put3(5'b11101);
    chk("t1_out_a", out3, 0);
    repeat (9) begin step(); chk("t1_gap_a", out3, 0); end
    put3(5'b10010);
    chk("t1_out_b", out3, 0);
    repeat (9) begin step(); chk("t1_gap_b", out3, 0); end
    put3(5'b00101);
    chk("t1_out_c", out3, 1);
    chk("t1_hv", hv3, 5'b10101);
    repeat (9) begin
      step();
      chk("t1_after_out", out3, 0);
      chk("t1_after_hv", hv3, 5'b10101);
    end

    // 2: back-to-back streaming, 4th accepted in DONE
    en3 = 1'b1;
    hv_in = 5'b11111; step(); chk("t2_o1", out3, 0);
    hv_in = 5'b11111; step(); chk("t2_o2", out3, 0);
    hv_in = 5'b00000; step(); chk("t2_o3", out3, 1); chk("t2_hv1", hv3, 5'b11111);
    hv_in = 5'b00000; step(); chk("t2_o4", out3, 0); chk("t2_hold1", hv3, 5'b11111);
    hv_in = 5'b00000; step(); chk("t2_o5", out3, 0);
    hv_in = 5'b10110; step(); chk("t2_o6", out3, 1); chk("t2_hv2", hv3, 5'b00000);
    en3 = 1'b0;
    step(); chk("t2_o7", out3, 0); chk("t2_hold2", hv3, 5'b00000);

    // 3: ties with N=2
    en2 = 1'b1;
    hv_in = 5'b11101; step();
    chk("t3_out_t0_a", out2a, 0);
    chk("t3_out_t1_a", out2b, 0);
    hv_in = 5'b10010; step();
    en2 = 1'b0;
    chk("t3_out_t0", out2a, 1);
    chk("t3_hv_t0", hv2a, 5'b10000);
    chk("t3_out_t1", out2b, 1);
    chk("t3_hv_t1", hv2b, 5'b11111);
    step();
    chk("t3_end_t0", out2a, 0);
    chk("t3_end_t1", out2b, 0);

    // 4: reset mid-bundle, en during reset ignored
    put3(5'b11111); chk("t4_o1", out3, 0);
    put3(5'b11111); chk("t4_o2", out3, 0);
    nrst = 1'b1;
    put3(5'b11111);
    nrst = 1'b0;
    chk("t4_rst_out", out3, 0);
    chk("t4_rst_hv", hv3, 0);
    put3(5'b00000); chk("t4_o3", out3, 0);
    put3(5'b00000); chk("t4_o4", out3, 0);
    put3(5'b00000); chk("t4_o5", out3, 1); chk("t4_hv", hv3, 5'b00000);

    // 5: idle hold with X on hv_in after a nonzero result
    put3(5'b01101);
    put3(5'b01101);
    put3(5'b10000);
    chk("t5_out", out3, 1);
    chk("t5_hv", hv3, 5'b01101);
    hv_in = 'x;
    repeat (50) begin
      step();
      chk("t5_x_out", out3, 0);
      chk("t5_x_hv", hv3, 5'b01101);
      chk("t5_x_out2", out2a, 0);
      chk("t5_x_hv1", hv1, 5'b00000);
    end

    // 6: N=1 passthrough, back-to-back
    en1 = 1'b1;
    hv_in = 5'b01010; step();
    chk("t6_out_a", out1, 1); chk("t6_hv_a", hv1, 5'b01010);
    hv_in = 5'b10101; step();
    chk("t6_out_b", out1, 1); chk("t6_hv_b", hv1, 5'b10101);
    en1 = 1'b0; hv_in = '0;
    step();
    chk("t6_out_c", out1, 0); chk("t6_hv_c", hv1, 5'b10101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
